serial_tx: RTL
==============

# serial_tx

Parallel-in, serial-out frame transmitter: accepts a DATA_W-bit word over a valid/ready handshake and drives it onto a single-bit line as start bit, LSB-first data, optional parity and stop bit. Each bit is held for CLKS_PER_BIT clock cycles. It is the driving end for the single-bit registered sampling path in the design; its `tx` output feeds a downstream flop-based receiver.

## Interface
- DATA_W, 8: data bits per frame; legal range 1 or more.
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range 1 or more. The bit counter is `$clog2(CLKS_PER_BIT)` wide, minimum 1 bit.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset. Assertion takes effect immediately; release is synchronous to the next `clk` edge.
- din  input  DATA_W  word to transmit; sampled only on an accepted transfer.
- din_valid  input  1  `din` is valid.
- din_ready  output  1  the block can accept a word. High exactly when the state is IDLE.
- tx  output  1  serial line. Registered; idles high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse during the final clock cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - `tx`=1.
  - When `din_valid && din_ready` at an edge: latch `din` into the shift register, clear the bit-cycle counter and the data-bit index, and go to START.
  - Changes to `din` after acceptance have no effect.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0, held for CLKS_PER_BIT cycles.
  - Then shift right and increment the bit index.
  - After DATA_W bits, go to PARITY if compiled in, else STOP.
- PARITY: `tx` = XOR of the latched data bits (even parity), held for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. `done`=1 in the last of those cycles. Then go to IDLE.
- `din_valid` while not in IDLE is ignored (`din_ready`=0). No word is lost or queued.
- Counter wrap: the bit-cycle counter counts 0..CLKS_PER_BIT-1. It wraps to 0 on the terminal count, and that wrap coincides with the state or bit advance.
- With CLKS_PER_BIT=1 every bit lasts exactly one cycle, and the counter remains a constant 0.

## Timing
- Reset values, forced while `rst`=0: state IDLE, `tx`=1, `busy`=0, `done`=0, `din_ready`=1, counters 0, shift register 0.
- While `rst`=0 no transfer is accepted, even though `din_ready`=1.
- Latency: acceptance at edge N puts `tx`=0 (start bit) from edge N+1. `busy`=1 from edge N+1.
- Frame length from N+1 to return to IDLE: (DATA_W+2)·CLKS_PER_BIT cycles, or (DATA_W+3)·CLKS_PER_BIT cycles with parity.
- Back-to-back frames: after STOP there is exactly one IDLE cycle (`tx`=1, `din_ready`=1) before the next start bit, provided `din_valid` is held high.
- Reset mid-frame: `tx` returns to 1 immediately and the frame is abandoned. `done` does not pulse. The next accepted word starts a clean frame.
- `busy` and `done` are registered and change only on `clk` edges, except on async reset.

## Configuration
- Macro `SERIAL_TX_PARITY_EN`:
  - Defined: the PARITY state exists, one even-parity bit is inserted between the last data bit and the stop bit, and the frame is DATA_W+3 bits.
  - Undefined: no PARITY state, no parity logic, and the frame is DATA_W+2 bits.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `din_valid`=1 and `din`=0xFF -> `tx`=1, `busy`=0, `done`=0; no frame starts until after release.
- **Single frame, no parity:** DATA_W=8, CLKS_PER_BIT=4, `din`=0xA5 -> `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total). `done` pulses in cycle 40; `din_ready` returns to 1 the next cycle.
- **Parity:** `SERIAL_TX_PARITY_EN` defined, `din`=0xA5 -> parity bit 0. With `din`=0x07 -> parity bit 1. Frame is 44 cycles.
- **Back-to-back:** 0x00 then 0xFF with `din_valid` held high -> exactly one `tx`=1 idle cycle between the stop bit of 0x00 and the start bit of 0xFF. Both frames are bit-exact.
- **Ignore while busy:** pulse `din_valid` with 0x3C mid-frame -> the current frame is unchanged and 0x3C is never transmitted.
- **Reset mid-frame, then CLKS_PER_BIT=1:**
  - Assert `rst` during DATA -> `tx`=1 immediately and no `done` pulse.
  - Then send 0x81 with CLKS_PER_BIT=1 -> 10-cycle frame 0,1,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, LSB-first data, optional
// even parity (compile with SERIAL_TX_PARITY_EN), stop bit; each bit CLKS_PER_BIT cycles.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic              tx_n, busy_n, done_n;
  logic              last;

`ifdef SERIAL_TX_PARITY_EN
  logic par, par_n;

  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction
`endif

  assign last      = (cnt == CNT_LAST);
  assign din_ready = (state == IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
`ifdef SERIAL_TX_PARITY_EN
    par_n   = par;
`endif
    // The bit-cycle counter wraps exactly when the state or bit index advances
    if (state != IDLE) cnt_n = last ? '0 : cnt + CW'(1);
    case (state)
      IDLE: begin
        if (din_valid) begin
          state_n = START;
          sh_n    = din;
          cnt_n   = '0;
          idx_n   = '0;
`ifdef SERIAL_TX_PARITY_EN
          par_n   = even_parity(din);
`endif
        end
      end
      START: if (last) state_n = DATA;
      DATA: begin
        if (last) begin
          sh_n = sh >> 1;
          if (idx == IDX_LAST) begin
            idx_n = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (last) state_n = STOP;
`endif
      STOP: if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so they are derived from the upcoming state
    tx_n = 1'b1;
    case (state_n)
      START:  tx_n = 1'b0;
      DATA:   tx_n = sh_n[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY: tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (cnt_n == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
`ifdef SERIAL_TX_PARITY_EN
      par   <= par_n;
`endif
    end
  end

endmodule
